tile_vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between the tile renderer's per-cell fetch (hard real-time) and a CPU/game-logic access port. It sequences each 8-pixel cell fetch (VRAM read of char/attribute, then font-ROM row lookup) and hands the renderer a ready-to-shift pattern byte. CPU accesses get every slot the fetch sequence does not use. Sits between the hvsync generator, the VRAM/font ROM and the tile renderer inside `wrapper_tiletest`.

---
 rtl/tile_arb_pkg.sv | 44 ++++
 rtl/tile_fetch_addr.sv | 39 +++
 rtl/tile_vram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_tile_vram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_arb_pkg.sv
// tile_arb_pkg: shared types and constants for the tile VRAM arbiter.
//   - video timing constants (pixel clock domain)
//   - VRAM / font ROM address and data widths
//   - fetch sequencer state encoding (IDLE, F0..F7)
//   - cell_t: one VRAM word, {attr, char}
package tile_arb_pkg;

    localparam int H_DISPLAY  = 256;
    localparam int H_TOTAL    = 309;
    localparam int V_DISPLAY  = 240;
    localparam int V_TOTAL    = 262;
    localparam int COLS       = H_DISPLAY / 8;

    localparam int POS_W      = 9;
    localparam int COL_W      = $clog2(COLS);
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int ROM_ADDR_W = 11;

    // Counter values the fetch trigger compares against, at counter width.
    localparam logic [POS_W-1:0] HPOS_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] HPOS_COL0     = POS_W'(H_TOTAL - 8);
    localparam logic [POS_W-1:0] HPOS_LAST_COL = POS_W'(8 * (COLS - 2));
    localparam logic [POS_W-1:0] VPOS_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] VPOS_DISPLAY  = POS_W'(V_DISPLAY);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_F3   = 4'd4,
        ST_F4   = 4'd5,
        ST_F5   = 4'd6,
        ST_F6   = 4'd7,
        ST_F7   = 4'd8
    } arb_state_t;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] ch;
    } cell_t;

endpackage

// File: rtl/tile_fetch_addr.sv
// tile_fetch_addr: decides whether a cell fetch starts at a given raster
// position and which cell it targets.
//   i_hpos, i_vpos : raster position the fetch would start on
//   o_trigger      : a fetch starts at this position
//   o_col          : target tile column
//   o_tl           : target line (only meaningful when o_trigger=1, < 240)
// Column 0 of a line is prefetched at the tail of the previous line's
// horizontal blank; columns 1..31 are fetched during the preceding cell.
module tile_fetch_addr
    import tile_arb_pkg::*;
(
    input  logic [POS_W-1:0] i_hpos,
    input  logic [POS_W-1:0] i_vpos,
    output logic             o_trigger,
    output logic [COL_W-1:0] o_col,
    output logic [7:0]       o_tl
);

    logic             w_is_col0;
    logic             w_is_coln;
    logic [POS_W-1:0] w_tl_full;

    always_comb begin
        w_is_col0 = (i_hpos == HPOS_COL0);
        w_is_coln = (i_hpos[2:0] == 3'd0) && (i_hpos <= HPOS_LAST_COL);

        // Column-0 prefetch serves the next line, wrapping at end of frame.
        if (w_is_col0) begin
            w_tl_full = (i_vpos == VPOS_LAST) ? '0 : i_vpos + 9'd1;
        end else begin
            w_tl_full = i_vpos;
        end

        o_col     = w_is_col0 ? '0 : i_hpos[7:3] + 5'd1;
        o_tl      = w_tl_full[7:0];
        o_trigger = (w_is_col0 || w_is_coln) && (w_tl_full < VPOS_DISPLAY);
    end

endmodule

// File: rtl/tile_vram_arbiter.sv
// tile_vram_arbiter: shares a single-port synchronous VRAM between the
// tile renderer's per-cell fetch and a CPU port, and sequences the
// char/attr read plus font-ROM lookup for each 8-pixel cell.
//
// Ports
//   i_clk, i_reset        pixel clock; synchronous active-low reset
//   i_hpos, i_vpos        raster counters from the hvsync generator
//   o_ram_*, i_ram_rdata  VRAM port (read data valid 1 clk after address)
//   o_rom_addr, i_rom_data font ROM port (data valid 1 clk after address)
//   o_tile_bits/attr/load pattern byte + attribute for the renderer;
//                         o_tile_load marks the cycle before the cell starts
//   i_cpu_*, o_cpu_*      CPU access port
//   o_dbg_state           current sequencer state (arb_state_t encoding)
//
// CPU handshake: a transfer happens on a rising edge where
// i_cpu_valid && o_cpu_ready. o_cpu_ready never depends on i_cpu_valid.
// A read returns o_cpu_rdata with a 1-clk o_cpu_rvalid strobe on the
// cycle after acceptance; writes have no response.
//
// Build option TILE_ARB_VBLANK_ONLY_EN: when defined the CPU is granted
// only in vertical blank while the sequencer is IDLE.
module tile_vram_arbiter
    import tile_arb_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [POS_W-1:0]      i_hpos,
    input  logic [POS_W-1:0]      i_vpos,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic                  o_ram_we,
    output logic [DATA_W-1:0]     o_ram_wdata,
    input  logic [DATA_W-1:0]     i_ram_rdata,
    output logic [ROM_ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]            i_rom_data,
    output logic [7:0]            o_tile_bits,
    output logic [7:0]            o_tile_attr,
    output logic                  o_tile_load,
    input  logic                  i_cpu_valid,
    input  logic                  i_cpu_we,
    input  logic [ADDR_W-1:0]     i_cpu_addr,
    input  logic [DATA_W-1:0]     i_cpu_wdata,
    output logic                  o_cpu_ready,
    output logic [DATA_W-1:0]     o_cpu_rdata,
    output logic                  o_cpu_rvalid,
    output logic [3:0]            o_dbg_state
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [7:0]        r_tl;
    logic [COL_W-1:0]  r_col;
    cell_t             r_cell;
    logic [7:0]        r_pend_bits;
    logic [7:0]        r_tile_bits;
    logic [7:0]        r_tile_attr;
    logic              r_tile_load;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic [POS_W-1:0]  w_hpos_next;
    logic [POS_W-1:0]  w_vpos_next;
    logic              w_trigger;
    logic [COL_W-1:0]  w_col;
    logic [7:0]        w_tl;
    logic              w_cpu_ready;
    logic              w_cpu_acc;
    logic [7:0]        w_char;

    // The trigger is evaluated on the next raster position so that F0 is
    // the cycle in which hpos equals the trigger point; this puts
    // tile_load 7 clks after the trigger and lets F7 chain straight into
    // the next F0.
    always_comb begin
        w_hpos_next = i_hpos + 9'd1;
        w_vpos_next = i_vpos;
        if (i_hpos == HPOS_LAST) begin
            w_hpos_next = '0;
            w_vpos_next = (i_vpos == VPOS_LAST) ? '0 : i_vpos + 9'd1;
        end
    end

    tile_fetch_addr u_fetch_addr (
        .i_hpos    (w_hpos_next),
        .i_vpos    (w_vpos_next),
        .o_trigger (w_trigger),
        .o_col     (w_col),
        .o_tl      (w_tl)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_trigger ? ST_F0 : ST_IDLE;
            ST_F0:   w_next = ST_F1;
            ST_F1:   w_next = ST_F2;
            ST_F2:   w_next = ST_F3;
            ST_F3:   w_next = ST_F4;
            ST_F4:   w_next = ST_F5;
            ST_F5:   w_next = ST_F6;
            ST_F6:   w_next = ST_F7;
            ST_F7:   w_next = w_trigger ? ST_F0 : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef TILE_ARB_VBLANK_ONLY_EN
        w_cpu_ready = (i_vpos >= VPOS_DISPLAY) && (r_state == ST_IDLE);
`else
        w_cpu_ready = (r_state != ST_F0);
`endif
        w_cpu_acc = i_cpu_valid && w_cpu_ready;
    end

    // VRAM port: video owns F0, otherwise an accepted CPU request drives it.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        if (r_state == ST_F0) begin
            o_ram_addr = {r_tl[7:3], r_col};
        end else if (w_cpu_acc) begin
            o_ram_addr  = i_cpu_addr;
            o_ram_we    = i_cpu_we;
            o_ram_wdata = i_cpu_we ? i_cpu_wdata : '0;
        end
    end

    // In F1 the char code is still on the VRAM bus, not yet in r_cell.
    always_comb begin
        w_char     = (r_state == ST_F1) ? i_ram_rdata[7:0] : r_cell.ch;
        o_rom_addr = {w_char, r_tl[2:0]};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_tl        <= '0;
            r_col       <= '0;
            r_cell      <= '0;
            r_pend_bits <= '0;
            r_tile_bits <= '0;
            r_tile_attr <= '0;
            r_tile_load <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_F0) begin
                r_tl  <= w_tl;
                r_col <= w_col;
            end
            if (r_state == ST_F1) begin
                r_cell <= cell_t'(i_ram_rdata);
            end
            if (r_state == ST_F2) begin
                r_pend_bits <= i_rom_data;
            end
            // Loaded on entry to F7 so the renderer sees them with the strobe.
            r_tile_load <= (r_state == ST_F6);
            if (r_state == ST_F6) begin
                r_tile_bits <= r_pend_bits;
                r_tile_attr <= r_cell.attr;
            end
            r_rd_pend <= w_cpu_acc && !i_cpu_we;
            if (r_rd_pend) begin
                r_cpu_rdata <= i_ram_rdata;
            end
        end
    end

    // Read data is taken straight off the VRAM bus in the strobe cycle and
    // held afterwards.
    assign o_cpu_rdata  = r_rd_pend ? i_ram_rdata : r_cpu_rdata;
    assign o_cpu_rvalid = r_rd_pend;
    assign o_cpu_ready  = w_cpu_ready;
    assign o_tile_bits  = r_tile_bits;
    assign o_tile_attr  = r_tile_attr;
    assign o_tile_load  = r_tile_load;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_tile_vram_arbiter.sv
// tb_tile_vram_arbiter: directed bench for tile_vram_arbiter with a
// synchronous VRAM model, a font ROM function and a settable raster counter.
module tb_tile_vram_arbiter;

    logic        clk;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  tile_bits;
    logic [7:0]  tile_attr;
    logic        tile_load;
    logic        cpu_valid;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [3:0]  dbg_state;

    bit   [15:0] vram [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];

`ifdef TILE_ARB_VBLANK_ONLY_EN
    localparam logic EXP_READY_DISP = 1'b0;
`else
    localparam logic EXP_READY_DISP = 1'b1;
`endif

    tile_vram_arbiter dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_hpos       (hpos),
        .i_vpos       (vpos),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_tile_bits  (tile_bits),
        .o_tile_attr  (tile_attr),
        .o_tile_load  (tile_load),
        .i_cpu_valid  (cpu_valid),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_ready  (cpu_ready),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_dbg_state  (dbg_state)
    );

    // Font ROM contents: 0x209 -> 0x3C, else low byte XOR {10110, addr[10:8]}.
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        if (a == 11'h209) return 8'h3C;
        return a[7:0] ^ {5'b10110, a[10:8]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (pre_we) vram[pre_addr] <= pre_data;
        else if (ram_we) vram[ram_addr] <= ram_wdata;
        ram_rdata <= vram[ram_addr];
        rom_data  <= rom_fn(rom_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: counter advances just after the edge, outputs settle by +2.
    task automatic step();
        @(posedge clk);
        #1;
        if (hpos == 9'd308) begin
            hpos = 9'd0;
            vpos = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
        end else begin
            hpos = hpos + 9'd1;
        end
        #1;
    endtask

    task automatic jump(input logic [8:0] h, input logic [8:0] v);
        hpos = h;
        vpos = v;
        #1;
    endtask

    // Let any fetch in flight finish; ends IDLE at (258, 9).
    task automatic park();
        jump(9'd250, 9'd9);
        repeat (8) step();
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        hpos      = 9'd252;
        vpos      = 9'd9;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        poke(10'h021, 16'h4541);
        poke(10'h020, 16'h1A2B);
        poke(10'h022, 16'h0511);
        poke(10'h155, 16'hBEEF);

        // Reset held for 7 clocks, released so that hpos=260 follows.
        jump(9'd252, 9'd9);
        repeat (7) step();
        reset = 1'b1;
        step();
        check_eq("rst_state",  32'(dbg_state),  32'd0);
        check_eq("rst_bits",   32'(tile_bits),  32'h0);
        check_eq("rst_attr",   32'(tile_attr),  32'h0);
        check_eq("rst_load",   32'(tile_load),  32'h0);
        check_eq("rst_rvalid", 32'(cpu_rvalid), 32'h0);
        check_eq("rst_rdata",  32'(cpu_rdata),  32'h0);
        check_eq("rst_we",     32'(ram_we),     32'h0);
        check_eq("rst_addr",   32'(ram_addr),   32'h0);
        check_eq("rst_ready",  32'(cpu_ready),  32'(EXP_READY_DISP));

        // Column 1 of line 9: VRAM 0x021 = 0x4541, ROM {0x41,1} = 0x3C.
        jump(9'd308, 9'd8);
        step();
        check_eq("c1_f0_state", 32'(dbg_state), 32'd1);
        check_eq("c1_f0_addr",  32'(ram_addr),  32'h021);
        check_eq("c1_f0_we",    32'(ram_we),    32'h0);
        check_eq("c1_f0_ready", 32'(cpu_ready), 32'h0);
        step();
        check_eq("c1_f1_rom",   32'(rom_addr),  32'h209);
        repeat (6) step();
        check_eq("c1_hpos",     32'(hpos),      32'd7);
        check_eq("c1_load",     32'(tile_load), 32'h1);
        check_eq("c1_bits",     32'(tile_bits), 32'h3C);
        check_eq("c1_attr",     32'(tile_attr), 32'h45);
        step();
        check_eq("c2_load_off", 32'(tile_load), 32'h0);
        check_eq("c2_chain_f0", 32'(dbg_state), 32'd1);
        check_eq("c2_addr",     32'(ram_addr),  32'h022);

        // Column-0 prefetch for line 8: VRAM 0x020 = 0x1A2B, ROM 0x158 -> 0xE9.
        park();
        jump(9'd300, 9'd7);
        step();
        check_eq("p0_state", 32'(dbg_state), 32'd1);
        check_eq("p0_addr",  32'(ram_addr),  32'h020);
        repeat (7) step();
        check_eq("p0_hpos",  32'(hpos),      32'd308);
        check_eq("p0_load",  32'(tile_load), 32'h1);
        check_eq("p0_bits",  32'(tile_bits), 32'hE9);
        check_eq("p0_attr",  32'(tile_attr), 32'h1A);

        // Last line of the frame prefetches line 0.
        park();
        jump(9'd300, 9'd261);
        step();
        check_eq("wrap_state", 32'(dbg_state), 32'd1);
        check_eq("wrap_addr",  32'(ram_addr),  32'h000);

        // Line 239 is the last fetched; line 240 is not.
        park();
        jump(9'd300, 9'd238);
        step();
        check_eq("l239_state", 32'(dbg_state), 32'd1);
        check_eq("l239_addr",  32'(ram_addr),  32'h3A0);
        park();
        jump(9'd300, 9'd239);
        step();
        check_eq("l240_idle",  32'(dbg_state), 32'd0);

        // Column 31 at hpos=240; nothing starts at hpos=248.
        park();
        jump(9'd239, 9'd9);
        step();
        check_eq("c31_state", 32'(dbg_state), 32'd1);
        check_eq("c31_addr",  32'(ram_addr),  32'h03F);
        repeat (7) step();
        check_eq("c31_load",  32'(tile_load), 32'h1);
        check_eq("c31_bits",  32'(tile_bits), 32'hB1);
        step();
        check_eq("h248_idle", 32'(dbg_state), 32'd0);

`ifndef TILE_ARB_VBLANK_ONLY_EN
        // CPU read held across the F0 at hpos=16.
        park();
        jump(9'd15, 9'd9);
        step();
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'h155;
        exp_q.push_back(16'hBEEF);
        #1;
        check_eq("rd_stall_ready", 32'(cpu_ready), 32'h0);
        check_eq("rd_stall_addr",  32'(ram_addr),  32'h023);
        step();
        check_eq("rd_acc_ready",   32'(cpu_ready),  32'h1);
        check_eq("rd_acc_addr",    32'(ram_addr),   32'h155);
        check_eq("rd_acc_rvalid",  32'(cpu_rvalid), 32'h0);
        step();
        cpu_valid = 1'b0;
        #1;
        check_eq("rd_rvalid", 32'(cpu_rvalid), 32'h1);
        check_eq("rd_data",   32'(cpu_rdata),  32'(exp_q.pop_front()));
        step();
        check_eq("rd_rvalid_off", 32'(cpu_rvalid), 32'h0);
        check_eq("rd_data_hold",  32'(cpu_rdata),  32'hBEEF);

        // CPU write to the cell being fetched lands after its F0.
        park();
        jump(9'd7, 9'd9);
        step();
        check_eq("wr_f0_addr", 32'(ram_addr), 32'h022);
        step();
        cpu_valid = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h022;
        cpu_wdata = 16'h1234;
        #1;
        check_eq("wr_ready", 32'(cpu_ready), 32'h1);
        check_eq("wr_we",    32'(ram_we),    32'h1);
        check_eq("wr_addr",  32'(ram_addr),  32'h022);
        check_eq("wr_wdata", 32'(ram_wdata), 32'h1234);
        step();
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        repeat (5) step();
        check_eq("wr_cur_load", 32'(tile_load), 32'h1);
        check_eq("wr_cur_attr", 32'(tile_attr), 32'h05);
        check_eq("wr_cur_bits", 32'(tile_bits), 32'h39);
        park();
        jump(9'd7, 9'd9);
        repeat (8) step();
        check_eq("wr_next_load", 32'(tile_load), 32'h1);
        check_eq("wr_next_attr", 32'(tile_attr), 32'h12);
        check_eq("wr_next_bits", 32'(tile_bits), 32'h10);
`endif

        // Reset in F2 with a CPU read outstanding.
        park();
        jump(9'd7, 9'd9);
        repeat (3) step();
        reset     = 1'b0;
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'h155;
        step();
        reset     = 1'b1;
        cpu_valid = 1'b0;
        #1;
        check_eq("mrst_state",  32'(dbg_state),  32'd0);
        check_eq("mrst_rvalid", 32'(cpu_rvalid), 32'h0);
        check_eq("mrst_bits",   32'(tile_bits),  32'h0);
        check_eq("mrst_rdata",  32'(cpu_rdata),  32'h0);
        repeat (4) step();
        check_eq("mrst_no_load", 32'(tile_load), 32'h0);
        step();
        check_eq("mrst_refetch", 32'(dbg_state), 32'd1);

        // Grant in active display versus vertical blank.
        park();
        jump(9'd260, 9'd100);
        check_eq("v100_ready", 32'(cpu_ready), 32'(EXP_READY_DISP));
        jump(9'd260, 9'd240);
        check_eq("v240_ready", 32'(cpu_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
